// File: rtl/onehot_pulse_decoder_if.sv
// Bundle between a priority-encoder source and the one-hot pulse decoder.
// The source drives the code and valid flag; the decoder returns the strobes and status.
interface onehot_pulse_decoder_if #(
  parameter int unsigned CNTW = 8
);
  logic            a;
  logic            b;
  logic            v;
  logic            ready;
  logic            y0;
  logic            y1;
  logic            y2;
  logic            y3;
  logic            busy;
  logic [1:0]      last_code;
  logic [CNTW-1:0] accept_cnt;
  logic [CNTW-1:0] drop_cnt;

  modport master (
    output a, b, v,
    input  ready, y0, y1, y2, y3, busy, last_code, accept_cnt, drop_cnt
  );

  modport slave (
    input  a, b, v,
    output ready, y0, y1, y2, y3, busy, last_code, accept_cnt, drop_cnt
  );
endinterface

// File: rtl/onehot_pulse_decoder.sv
// Turns an accepted 2-bit code into a HOLD-cycle one-hot strobe followed by a GAP-cycle idle gap.
// Codes arriving while busy are discarded and counted.
module onehot_pulse_decoder #(
  parameter int unsigned HOLD = 4,
  parameter int unsigned GAP  = 1,
  parameter int unsigned CNTW = 8
) (
  input logic                   clk,
  input logic                   rst,
  onehot_pulse_decoder_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StHold, StGap} state_e;

  state_e          state_q;
  logic [7:0]      cnt_q;
  logic [3:0]      y_q;
  logic            busy_q;
  logic            ready_q;
  logic [1:0]      last_code_q;
  logic [CNTW-1:0] accept_cnt_q;
  logic [CNTW-1:0] drop_cnt_q;

  logic [1:0] code;
  assign code = {bus.a, bus.b};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      y_q          <= '0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b1;
      last_code_q  <= 2'b00;
      accept_cnt_q <= '0;
      drop_cnt_q   <= '0;
    end else begin
      // ready_q mirrors state_q == StIdle, so it is the accept/drop qualifier
      if (bus.v && !ready_q && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (bus.v) begin
            state_q     <= StHold;
            cnt_q       <= 8'(HOLD - 1);
            y_q         <= 4'(4'b0001 << code);
            busy_q      <= 1'b1;
            ready_q     <= 1'b0;
            last_code_q <= code;
            if (accept_cnt_q != '1) begin
              accept_cnt_q <= accept_cnt_q + 1'b1;
            end
          end
        end
        StHold: begin
          if (cnt_q == 8'd0) begin
            y_q <= '0;
            if (GAP != 0) begin
              state_q <= StGap;
              cnt_q   <= 8'(GAP - 1);
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        StGap: begin
          if (cnt_q == 8'd0) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          y_q     <= '0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready      = ready_q;
  assign bus.y0         = y_q[0];
  assign bus.y1         = y_q[1];
  assign bus.y2         = y_q[2];
  assign bus.y3         = y_q[3];
  assign bus.busy       = busy_q;
  assign bus.last_code  = last_code_q;
  assign bus.accept_cnt = accept_cnt_q;
  assign bus.drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Directed bench: one decoder with GAP=1 and one with GAP=0, hand-computed expectations.
module tb_onehot_pulse_decoder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic started = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  onehot_pulse_decoder_if #(.CNTW(8)) bus0 ();
  onehot_pulse_decoder_if #(.CNTW(8)) bus1 ();

  onehot_pulse_decoder #(.HOLD(4), .GAP(1), .CNTW(8)) u_dut_gap1 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  onehot_pulse_decoder #(.HOLD(4), .GAP(0), .CNTW(8)) u_dut_gap0 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  logic [3:0] y_0;
  logic [3:0] y_1;
  assign y_0 = {bus0.y3, bus0.y2, bus0.y1, bus0.y0};
  assign y_1 = {bus1.y3, bus1.y2, bus1.y1, bus1.y0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("onehot_gap1", 32'($countones(y_0) <= 1), 32'd1);
      check("onehot_gap0", 32'($countones(y_1) <= 1), 32'd1);
    end
  end

  initial begin
    bus0.a = 1'b0; bus0.b = 1'b0; bus0.v = 1'b0;
    bus1.a = 1'b0; bus1.b = 1'b0; bus1.v = 1'b0;
    #2;

    // Reset then idle
    do_reset(2);
    started = 1'b1;
    repeat (5) tick();
    check("idle_y", 32'(y_0), 32'h0);
    check("idle_ready", 32'(bus0.ready), 32'd1);
    check("idle_busy", 32'(bus0.busy), 32'd0);
    check("idle_acc", 32'(bus0.accept_cnt), 32'd0);
    check("idle_drop", 32'(bus0.drop_cnt), 32'd0);
    check("idle_last", 32'(bus0.last_code), 32'd0);

    // Single accept of code 2
    bus0.a = 1'b1; bus0.b = 1'b0; bus0.v = 1'b1;
    tick();
    bus0.v = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("single_y", 32'(y_0), 32'h4);
      check("single_busy", 32'(bus0.busy), 32'd1);
      check("single_ready", 32'(bus0.ready), 32'd0);
      tick();
    end
    check("single_gap_y", 32'(y_0), 32'h0);
    check("single_gap_busy", 32'(bus0.busy), 32'd1);
    check("single_gap_ready", 32'(bus0.ready), 32'd0);
    tick();
    check("single_ready6", 32'(bus0.ready), 32'd1);
    check("single_busy6", 32'(bus0.busy), 32'd0);
    check("single_last", 32'(bus0.last_code), 32'd2);
    check("single_acc", 32'(bus0.accept_cnt), 32'd1);

    // Drop while busy
    do_reset(1);
    bus0.a = 1'b0; bus0.b = 1'b1; bus0.v = 1'b1;
    tick();
    bus0.a = 1'b1; bus0.b = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("drop_y", 32'(y_0), 32'h2);
      tick();
    end
    bus0.v = 1'b0;
    check("drop_y4", 32'(y_0), 32'h2);
    tick();
    check("drop_gap_y", 32'(y_0), 32'h0);
    tick();
    check("drop_cnt", 32'(bus0.drop_cnt), 32'd3);
    check("drop_acc", 32'(bus0.accept_cnt), 32'd1);
    check("drop_last", 32'(bus0.last_code), 32'd1);
    check("drop_ready", 32'(bus0.ready), 32'd1);

    // All four codes in sequence
    do_reset(1);
    for (int c = 0; c < 4; c++) begin
      int budget = 20;
      while (!bus0.ready && budget > 0) begin
        tick();
        budget--;
      end
      if (budget == 0) check("seq_ready_timeout", 32'd0, 32'd1);
      bus0.a = c[1]; bus0.b = c[0]; bus0.v = 1'b1;
      tick();
      bus0.v = 1'b0;
      for (int k = 0; k < 4; k++) begin
        check("seq_y", 32'(y_0), 32'(4'b0001 << c));
        tick();
      end
      check("seq_after_y", 32'(y_0), 32'h0);
    end
    check("seq_acc", 32'(bus0.accept_cnt), 32'd4);
    check("seq_drop", 32'(bus0.drop_cnt), 32'd0);
    check("seq_last", 32'(bus0.last_code), 32'd3);

    // GAP=0 back-to-back: code presented in last HOLD cycle is dropped, next cycle accepted
    do_reset(1);
    bus1.a = 1'b0; bus1.b = 1'b0; bus1.v = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("b2b_ready_idle", 32'(bus1.ready), 32'd1);
      tick();
      bus1.v = 1'b0;
      check("b2b_y", 32'(y_1), 32'h1);
      repeat (3) tick();
      check("b2b_ready_last", 32'(bus1.ready), 32'd0);
      check("b2b_y_last", 32'(y_1), 32'h1);
      bus1.v = 1'b1;
      tick();
    end
    bus1.v = 1'b0;
    check("b2b_ready_end", 32'(bus1.ready), 32'd1);
    check("b2b_y_end", 32'(y_1), 32'h0);
    check("b2b_acc", 32'(bus1.accept_cnt), 32'd3);
    check("b2b_drop", 32'(bus1.drop_cnt), 32'd3);

    // Reset mid-pulse, with a competing valid code
    do_reset(1);
    bus0.a = 1'b1; bus0.b = 1'b1; bus0.v = 1'b1;
    tick();
    bus0.v = 1'b0;
    check("rstmid_y1", 32'(y_0), 32'h8);
    tick();
    check("rstmid_y2", 32'(y_0), 32'h8);
    rst = 1'b1;
    bus0.v = 1'b1;
    tick();
    rst = 1'b0;
    bus0.v = 1'b0;
    check("rstmid_y", 32'(y_0), 32'h0);
    check("rstmid_busy", 32'(bus0.busy), 32'd0);
    check("rstmid_ready", 32'(bus0.ready), 32'd1);
    check("rstmid_acc", 32'(bus0.accept_cnt), 32'd0);
    check("rstmid_drop", 32'(bus0.drop_cnt), 32'd0);
    check("rstmid_last", 32'(bus0.last_code), 32'd0);

    tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
